pong_game_ctrl: RTL

- Game-sequencing controller for the VGA pong datapath.
- Decides when the ball is loaded, when it moves, when a miss is declared, and when the game ends.
- Keeps a BCD score, remaining lives and a speed level; all decisions are taken on the per-frame update tick.
- Sits between the sync/collision logic (frame tick, ball position, paddle-hit flag) and the ball-motion register block.

---
 rtl/pong_game_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Game-sequencing controller for the VGA pong datapath: serve/play/miss/over
// sequencing, BCD score, lives and speed level, all advanced on the frame tick.
module pong_game_ctrl #(
   parameter int LIVES            = 3,
   parameter int MISS_Y           = 470,
   parameter int MISS_FRAMES      = 60,
   parameter int HITS_PER_SPEEDUP = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       serve_btn,
   input  logic [8:0] ball_y,
   input  logic       paddle_hit,
   output logic       ball_load,
   output logic       ball_step,
   output logic [1:0] speed,
   output logic [3:0] score_tens,
   output logic [3:0] score_ones,
   output logic [1:0] lives,
   output logic       game_over,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_MISS  = 3'd3,
      S_OVER  = 3'd4
   } state_e;

   localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
   localparam logic [8:0] MISS_Y_C    = 9'(MISS_Y);
   localparam logic [7:0] MISS_FRM_C  = 8'(MISS_FRAMES);
   localparam logic [3:0] HITS_SPD_C  = 4'(HITS_PER_SPEEDUP);

   state_e     state_q, state_d;
   logic       ball_load_q, ball_load_d;
   logic       ball_step_q, ball_step_d;
   logic [1:0] speed_q, speed_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic [1:0] lives_q, lives_d;
   logic       game_over_q, game_over_d;
   logic       hit_q, hit_d;
   logic [3:0] hit_cnt_q, hit_cnt_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       sync1_q, sync2_q, sync3_q;

   logic       serve_evt;
   logic [3:0] hit_cnt_inc;
   logic [7:0] frame_cnt_inc;

   // sync3_q holds the previous synchronized level so a held button yields one event
   assign serve_evt     = sync2_q & ~sync3_q;
   assign hit_cnt_inc   = hit_cnt_q + 4'd1;
   assign frame_cnt_inc = frame_cnt_q + 8'd1;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ball_load_q <= 1'b0;
         ball_step_q <= 1'b0;
         speed_q     <= 2'd0;
         tens_q      <= 4'd0;
         ones_q      <= 4'd0;
         lives_q     <= LIVES_INIT;
         game_over_q <= 1'b0;
         hit_q       <= 1'b0;
         hit_cnt_q   <= 4'd0;
         frame_cnt_q <= 8'd0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync3_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ball_load_q <= ball_load_d;
         ball_step_q <= ball_step_d;
         speed_q     <= speed_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         lives_q     <= lives_d;
         game_over_q <= game_over_d;
         hit_q       <= hit_d;
         hit_cnt_q   <= hit_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         sync1_q     <= serve_btn;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      ball_load_d = 1'b0;
      ball_step_d = 1'b0;
      speed_d     = speed_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      lives_d     = lives_q;
      hit_cnt_d   = hit_cnt_q;
      frame_cnt_d = frame_cnt_q;

      if (frame_tick)
         hit_d = 1'b0;
      else if (state_q == S_PLAY && paddle_hit)
         hit_d = 1'b1;
      else
         hit_d = hit_q;

      case (state_q)
         S_IDLE: begin
            state_d     = S_SERVE;
            ball_load_d = 1'b1;
         end
         S_SERVE: begin
            if (serve_evt) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (frame_tick) begin
               if (ball_y >= MISS_Y_C) begin
                  // a hit latched in the same frame is dropped: the miss wins
                  state_d     = S_MISS;
                  lives_d     = lives_q - 2'd1;
                  frame_cnt_d = 8'd0;
               end else begin
                  ball_step_d = 1'b1;
                  if (hit_q) begin
                     if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
                        if (ones_q == 4'd9) begin
                           ones_d = 4'd0;
                           tens_d = tens_q + 4'd1;
                        end else begin
                           ones_d = ones_q + 4'd1;
                        end
                     end
                     if (hit_cnt_inc == HITS_SPD_C) begin
                        hit_cnt_d = 4'd0;
                        if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
                     end else begin
                        hit_cnt_d = hit_cnt_inc;
                     end
                  end
               end
            end
         end
         S_MISS: begin
            if (frame_tick) begin
               frame_cnt_d = frame_cnt_inc;
               if (frame_cnt_inc == MISS_FRM_C) begin
                  if (lives_q == 2'd0) begin
                     state_d = S_OVER;
                  end else begin
                     state_d     = S_SERVE;
                     ball_load_d = 1'b1;
                     speed_d     = 2'd0;
                     hit_cnt_d   = 4'd0;
                  end
               end
            end
         end
         S_OVER: begin
            if (serve_evt) begin
               state_d     = S_SERVE;
               ball_load_d = 1'b1;
               tens_d      = 4'd0;
               ones_d      = 4'd0;
               lives_d     = LIVES_INIT;
               speed_d     = 2'd0;
               hit_cnt_d   = 4'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      game_over_d = (state_d == S_OVER);
   end

   assign ball_load  = ball_load_q;
   assign ball_step  = ball_step_q;
   assign speed      = speed_q;
   assign score_tens = tens_q;
   assign score_ones = ones_q;
   assign lives      = lives_q;
   assign game_over  = game_over_q;
   assign state      = state_q;

endmodule
